// File: rtl/conv_frame_ctrl.sv
// Sensor frame controller for a 3x3 convolution datapath: pixel counters,
// border-masked window valid, output-valid delay line and per-frame mode latch.
module conv_frame_ctrl #(
  parameter int IMG_W    = 1280,
  parameter int IMG_H    = 960,
  parameter int BORDER   = 10,
  parameter int PIPE_LAT = 3
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [1:0]  iMODE,
  input  logic        iMODE_WR,
  output logic        oMODE_ACK,
  output logic [1:0]  oMODE,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic        oLB_CLKEN,
  output logic        oWIN_VALID,
  output logic        oOUT_DVAL,
  output logic        oFRAME_DONE,
  output logic        oSHORT,
  output logic        oBUSY,
  output logic [15:0] oFRAME_CNT
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(PIPE_LAT - 1);
  localparam logic [FW-1:0] F_PRE  = FW'((PIPE_LAT > 1) ? PIPE_LAT - 2 : 0);
  localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
  localparam logic [10:0] Y_LAST = 11'(IMG_H - 1);
  localparam logic [10:0] X_LO   = 11'(BORDER);
  localparam logic [10:0] X_HI   = 11'(IMG_W - 1 - BORDER);
  localparam logic [10:0] Y_LO   = 11'(BORDER);
  localparam logic [10:0] Y_HI   = 11'(IMG_H - 1 - BORDER);

  state_t              r_state;
  logic [FW-1:0]       r_fcnt;
  logic [PIPE_LAT-1:0] r_dly;
  logic                r_fval_d;
  logic                r_armed;
  logic                r_pend;
  logic [1:0]          r_pend_mode;

  logic w_rise;
  logic w_end;
  logic w_win;

  // r_armed blocks a frame start on the first cycle after reset, so an
  // iFVAL already high at release is not mistaken for a rising edge.
  assign w_rise     = iFVAL & ~r_fval_d & r_armed;
  assign w_end      = iDVAL & (oX_Cont == X_LAST) & (oY_Cont == Y_LAST);
  assign w_win      = (oX_Cont >= 11'd2) && (oY_Cont >= 11'd2) &&
                      (oX_Cont >= X_LO) && (oX_Cont <= X_HI) &&
                      (oY_Cont >= Y_LO) && (oY_Cont <= Y_HI);
  assign oLB_CLKEN  = (r_state == ACTIVE) & iDVAL;
  assign oOUT_DVAL  = r_dly[PIPE_LAT-1];
  assign oBUSY      = (r_state != IDLE);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state     <= IDLE;
      r_fcnt      <= '0;
      r_dly       <= '0;
      r_fval_d    <= 1'b0;
      r_armed     <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_mode <= '0;
      oMODE_ACK   <= 1'b0;
      oMODE       <= '0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oWIN_VALID  <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oSHORT      <= 1'b0;
      oFRAME_CNT  <= '0;
    end else begin
      r_fval_d    <= iFVAL;
      r_armed     <= 1'b1;
      r_dly       <= PIPE_LAT'({r_dly, oLB_CLKEN});
      oMODE_ACK   <= iMODE_WR;
      oWIN_VALID  <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oSHORT      <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= ACTIVE;
            oX_Cont <= '0;
            oY_Cont <= '0;
            r_pend  <= 1'b0;
            if (r_pend) oMODE <= r_pend_mode;
          end
        end
        ACTIVE: begin
          if (iDVAL) begin
            oWIN_VALID <= w_win;
            if (oX_Cont == X_LAST) begin
              oX_Cont <= '0;
              oY_Cont <= (oY_Cont == Y_LAST) ? '0 : oY_Cont + 11'd1;
            end else begin
              oX_Cont <= oX_Cont + 11'd1;
            end
          end
          if (w_end || !iFVAL) begin
            r_state <= FLUSH;
            r_fcnt  <= '0;
            oSHORT  <= ~w_end;
            if (PIPE_LAT == 1) begin
              oFRAME_DONE <= 1'b1;
              oFRAME_CNT  <= oFRAME_CNT + 16'd1;
            end
          end
        end
        FLUSH: begin
          // Done/count are raised on entry to the last flush cycle so the
          // pulse lines up with the final pixel leaving the delay line.
          if (r_fcnt == F_LAST) begin
            r_state <= IDLE;
          end else begin
            r_fcnt <= r_fcnt + FW'(1);
            if (r_fcnt == F_PRE) begin
              oFRAME_DONE <= 1'b1;
              oFRAME_CNT  <= oFRAME_CNT + 16'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // Placed after the frame-start clear so a coincident write stays pending.
      if (iMODE_WR) begin
        r_pend      <= 1'b1;
        r_pend_mode <= (iMODE == 2'd3) ? 2'd0 : iMODE;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl on an 8x4 image, border 1, latency 3.
module tb_conv_frame_ctrl;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int B  = 1;
  localparam int PL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        iFVAL, iDVAL, iMODE_WR;
  logic [1:0]  iMODE;
  logic        oMODE_ACK, oLB_CLKEN, oWIN_VALID, oOUT_DVAL, oFRAME_DONE, oSHORT, oBUSY;
  logic [1:0]  oMODE;
  logic [10:0] oX_Cont, oY_Cont;
  logic [15:0] oFRAME_CNT;
  logic [46:0] all_out;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [1:0]  m_mode;
  logic [1:0]  m_pend_mode;
  logic        m_pend;
  int unsigned m_frames;

  always #5 clk = ~clk;

  conv_frame_ctrl #(.IMG_W(W), .IMG_H(H), .BORDER(B), .PIPE_LAT(PL)) dut (
    .iCLK(clk), .iRST(rst), .iFVAL(iFVAL), .iDVAL(iDVAL), .iMODE(iMODE),
    .iMODE_WR(iMODE_WR), .oMODE_ACK(oMODE_ACK), .oMODE(oMODE), .oX_Cont(oX_Cont),
    .oY_Cont(oY_Cont), .oLB_CLKEN(oLB_CLKEN), .oWIN_VALID(oWIN_VALID),
    .oOUT_DVAL(oOUT_DVAL), .oFRAME_DONE(oFRAME_DONE), .oSHORT(oSHORT),
    .oBUSY(oBUSY), .oFRAME_CNT(oFRAME_CNT)
  );

  assign all_out = {oMODE_ACK, oMODE, oX_Cont, oY_Cont, oLB_CLKEN, oWIN_VALID,
                    oOUT_DVAL, oFRAME_DONE, oSHORT, oBUSY, oFRAME_CNT};

  function automatic bit win_ok(input int x, input int y);
    return (x >= 2) && (y >= 2) && (x >= B) && (x <= W - 1 - B) &&
           (y >= B) && (y <= H - 1 - B);
  endfunction

  // Inputs change at the falling edge; outputs are observed 1 ns later.
  task automatic tick(input logic fval, input logic dval, input logic wr, input logic [1:0] md);
    @(negedge clk);
    iFVAL = fval; iDVAL = dval; iMODE_WR = wr; iMODE = md;
    if (wr) begin
      m_pend = 1'b1;
      m_pend_mode = (md == 2'd3) ? 2'd0 : md;
    end
    #1;
  endtask

  task automatic model_start();
    if (m_pend) m_mode = m_pend_mode;
    m_pend = 1'b0;
  endtask

  task automatic run_frame(input int unsigned npix, input bit wr_start, input logic [1:0] wmode,
                           output logic [1:0] mode_seen, output int unsigned n_short,
                           output int unsigned n_done, output int unsigned done_ofs,
                           output int unsigned busy_after);
    n_short = 0; n_done = 0; done_ofs = 99; busy_after = 0; mode_seen = 2'bxx;
    tick(1'b0, 1'b0, 1'b0, 2'd0);
    model_start();
    tick(1'b1, 1'b0, wr_start, wmode);
    for (int unsigned k = 0; k < npix; k++) begin
      tick(1'b1, 1'b1, 1'b0, 2'd0);
      if (k == 0) mode_seen = oMODE;
      if (oSHORT) n_short++;
      if (oFRAME_DONE) n_done++;
    end
    for (int unsigned d = 0; d < 8; d++) begin
      tick(1'b0, 1'b0, 1'b0, 2'd0);
      if (oSHORT) n_short++;
      if (oFRAME_DONE) begin n_done++; done_ofs = d; end
      if (oBUSY) busy_after++;
    end
    m_frames++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    @(negedge clk);
    rst = 1'b0;
    m_mode = 2'd0; m_pend = 1'b0; m_pend_mode = 2'd0; m_frames = 0;
  endtask

  task automatic test_full_frame();
    bit exp_cl [0:47];
    int unsigned wins;
    bit fv, dv, e_win;
    int p;
    wins = 0;
    for (int t = 0; t <= 42; t++) begin
      fv = (t >= 4 && t <= 36);
      dv = (t >= 5 && t <= 36) ? 1'b1 : ((t < 4) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (t == 4) model_start();
      tick(fv, dv, 1'b0, 2'd0);
      exp_cl[t] = (t >= 5 && t <= 36);
      checks++;
      if (oLB_CLKEN !== exp_cl[t]) begin failures++; $display("FAIL ff_clken t=%0d got=%b exp=%b", t, oLB_CLKEN, exp_cl[t]); end
      if (t >= 3) begin
        checks++;
        if (oOUT_DVAL !== exp_cl[t-3]) begin failures++; $display("FAIL ff_out_dval t=%0d got=%b exp=%b", t, oOUT_DVAL, exp_cl[t-3]); end
      end
      if (t >= 5 && t <= 36) begin
        p = t - 5;
        checks++;
        if (oX_Cont !== 11'(p % W) || oY_Cont !== 11'(p / W)) begin
          failures++; $display("FAIL ff_xy pix=%0d got=%0d/%0d exp=%0d/%0d", p, oX_Cont, oY_Cont, p % W, p / W);
        end
        checks++;
        if (oMODE !== m_mode) begin failures++; $display("FAIL ff_mode got=%0d exp=%0d", oMODE, m_mode); end
      end
      e_win = (t >= 6 && t <= 37) ? win_ok((t - 6) % W, (t - 6) / W) : 1'b0;
      checks++;
      if (oWIN_VALID !== e_win) begin failures++; $display("FAIL ff_win t=%0d got=%b exp=%b", t, oWIN_VALID, e_win); end
      if (oWIN_VALID === 1'b1) wins++;
      checks++;
      if (oFRAME_DONE !== (t == 39)) begin failures++; $display("FAIL ff_done t=%0d got=%b exp=%b", t, oFRAME_DONE, (t == 39)); end
      checks++;
      if (oBUSY !== (t >= 5 && t <= 39)) begin failures++; $display("FAIL ff_busy t=%0d got=%b", t, oBUSY); end
      checks++;
      if (oSHORT !== 1'b0) begin failures++; $display("FAIL ff_short t=%0d got=%b exp=0", t, oSHORT); end
      checks++;
      if (oFRAME_CNT !== 16'((t >= 39) ? m_frames + 1 : m_frames)) begin
        failures++; $display("FAIL ff_cnt t=%0d got=%0d", t, oFRAME_CNT);
      end
    end
    m_frames++;
    checks++;
    if (wins !== 5) begin failures++; $display("FAIL ff_win_count got=%0d exp=5", wins); end
  endtask

  task automatic test_mode_write();
    logic [1:0] ms;
    int unsigned ns, nd, dof, ba;
    tick(1'b0, 1'b0, 1'b1, 2'd1);
    checks++;
    if (oMODE_ACK !== 1'b0) begin failures++; $display("FAIL mw_ack_early got=%b exp=0", oMODE_ACK); end
    tick(1'b0, 1'b0, 1'b0, 2'd0);
    checks++;
    if (oMODE_ACK !== 1'b1) begin failures++; $display("FAIL mw_ack got=%b exp=1", oMODE_ACK); end
    tick(1'b0, 1'b0, 1'b0, 2'd0);
    checks++;
    if (oMODE_ACK !== 1'b0 || oMODE !== 2'd0) begin failures++; $display("FAIL mw_idle got=%b/%0d exp=0/0", oMODE_ACK, oMODE); end
    run_frame(32, 1'b0, 2'd0, ms, ns, nd, dof, ba);
    checks++;
    if (ms !== 2'd1 || ms !== m_mode) begin failures++; $display("FAIL mw_mode1 got=%0d exp=1", ms); end
    checks++;
    if (ns !== 0 || nd !== 1 || dof !== 2 || ba !== 3) begin
      failures++; $display("FAIL mw_frame got=short%0d done%0d ofs%0d busy%0d exp=0/1/2/3", ns, nd, dof, ba);
    end
    tick(1'b0, 1'b0, 1'b1, 2'd3);
    tick(1'b0, 1'b0, 1'b0, 2'd0);
    checks++;
    if (oMODE_ACK !== 1'b1) begin failures++; $display("FAIL mw_ack3 got=%b exp=1", oMODE_ACK); end
    run_frame(32, 1'b0, 2'd0, ms, ns, nd, dof, ba);
    checks++;
    if (ms !== 2'd0 || ms !== m_mode) begin failures++; $display("FAIL mw_mode3 got=%0d exp=0", ms); end
    tick(1'b0, 1'b0, 1'b1, 2'd2);
    tick(1'b0, 1'b0, 1'b1, 2'd1);
    checks++;
    if (oMODE_ACK !== 1'b1) begin failures++; $display("FAIL mw_b2b_ack got=%b exp=1", oMODE_ACK); end
    tick(1'b0, 1'b0, 1'b0, 2'd0);
    run_frame(32, 1'b0, 2'd0, ms, ns, nd, dof, ba);
    checks++;
    if (ms !== 2'd1 || ms !== m_mode) begin failures++; $display("FAIL mw_b2b got=%0d exp=1", ms); end
    checks++;
    if (oFRAME_CNT !== 16'(m_frames)) begin failures++; $display("FAIL mw_cnt got=%0d exp=%0d", oFRAME_CNT, m_frames); end
  endtask

  task automatic test_coincident();
    logic [1:0] ms;
    int unsigned ns, nd, dof, ba;
    run_frame(32, 1'b1, 2'd2, ms, ns, nd, dof, ba);
    checks++;
    if (ms !== 2'd1 || ms !== m_mode) begin failures++; $display("FAIL co_same_frame got=%0d exp=1", ms); end
    run_frame(32, 1'b0, 2'd0, ms, ns, nd, dof, ba);
    checks++;
    if (ms !== 2'd2 || ms !== m_mode) begin failures++; $display("FAIL co_next_frame got=%0d exp=2", ms); end
  endtask

  task automatic test_short();
    logic [1:0] ms;
    int unsigned ns, nd, dof, ba;
    run_frame(10, 1'b0, 2'd0, ms, ns, nd, dof, ba);
    checks++;
    if (ns !== 1) begin failures++; $display("FAIL sh_pulse got=%0d exp=1", ns); end
    checks++;
    if (nd !== 1 || dof !== 3) begin failures++; $display("FAIL sh_done got=%0d@%0d exp=1@3", nd, dof); end
    checks++;
    if (ba !== 4) begin failures++; $display("FAIL sh_busy got=%0d exp=4", ba); end
    checks++;
    if (oFRAME_CNT !== 16'(m_frames)) begin failures++; $display("FAIL sh_cnt got=%0d exp=%0d", oFRAME_CNT, m_frames); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] ms;
    int unsigned ns, nd, dof, ba;
    tick(1'b0, 1'b0, 1'b0, 2'd0);
    model_start();
    tick(1'b1, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b1, 1'b0, 2'd0);
    checks++;
    if (oX_Cont !== 11'd5) begin failures++; $display("FAIL rm_pre_x got=%0d exp=5", oX_Cont); end
    rst = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL rm_immediate got=%h exp=0", all_out); end
    repeat (2) tick(1'b1, 1'b1, 1'b0, 2'd0);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL rm_held got=%h exp=0", all_out); end
    @(negedge clk);
    rst = 1'b0;
    m_mode = 2'd0; m_pend = 1'b0; m_frames = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0, 2'd0);
      checks++;
      if (oLB_CLKEN !== 1'b0 || oBUSY !== 1'b0) begin
        failures++; $display("FAIL rm_no_edge i=%0d got=%b/%b exp=0/0", i, oLB_CLKEN, oBUSY);
      end
    end
    run_frame(32, 1'b0, 2'd0, ms, ns, nd, dof, ba);
    checks++;
    if (nd !== 1 || oFRAME_CNT !== 16'(m_frames)) begin
      failures++; $display("FAIL rm_recover got=done%0d cnt%0d exp=1/%0d", nd, oFRAME_CNT, m_frames);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int unsigned lim, k, nw, obs_win, exp_win, n_sh, n_dn, guard;
      bit sh, dv;
      nw = $urandom_range(0, 2);
      tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 2'd0);
      checks++;
      if (oLB_CLKEN !== 1'b0) begin failures++; $display("FAIL rnd_idle_clken got=%b exp=0", oLB_CLKEN); end
      for (int i = 0; i < int'(nw); i++) tick(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
      tick(1'b0, 1'b0, 1'b0, 2'd0);
      sh = 1'($urandom_range(0, 1));
      lim = sh ? $urandom_range(1, 31) : 32;
      model_start();
      tick(1'b1, 1'b0, 1'b0, 2'd0);
      k = 0; obs_win = 0; exp_win = 0; n_sh = 0; n_dn = 0; guard = 0;
      while (k < lim && guard < 200) begin
        dv = ($urandom_range(0, 3) != 0);
        tick(1'b1, dv, 1'b0, 2'd0);
        guard++;
        if (oWIN_VALID === 1'b1) obs_win++;
        if (oSHORT === 1'b1) n_sh++;
        if (oFRAME_DONE === 1'b1) n_dn++;
        if (guard == 1) begin
          checks++;
          if (oMODE !== m_mode) begin failures++; $display("FAIL rnd_mode f=%0d got=%0d exp=%0d", f, oMODE, m_mode); end
        end
        checks++;
        if (oLB_CLKEN !== dv) begin failures++; $display("FAIL rnd_clken got=%b exp=%b", oLB_CLKEN, dv); end
        if (dv) begin
          checks++;
          if (oX_Cont !== 11'(k % W) || oY_Cont !== 11'(k / W)) begin
            failures++; $display("FAIL rnd_xy pix=%0d got=%0d/%0d exp=%0d/%0d", k, oX_Cont, oY_Cont, k % W, k / W);
          end
          if (win_ok(int'(k % W), int'(k / W))) exp_win++;
          k++;
        end
      end
      checks++;
      if (k < lim) begin failures++; $display("FAIL rnd_timeout got=%0d exp=%0d", k, lim); end
      tick(1'b0, 1'b0, 1'b0, 2'd0);
      if (oWIN_VALID === 1'b1) obs_win++;
      if (oSHORT === 1'b1) n_sh++;
      if (oFRAME_DONE === 1'b1) n_dn++;
      for (int d = 0; d < 8; d++) begin
        tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 2'd0);
        if (oWIN_VALID === 1'b1) obs_win++;
        if (oSHORT === 1'b1) n_sh++;
        if (oFRAME_DONE === 1'b1) n_dn++;
        checks++;
        if (oLB_CLKEN !== 1'b0) begin failures++; $display("FAIL rnd_flush_clken d=%0d got=%b exp=0", d, oLB_CLKEN); end
      end
      m_frames++;
      checks++;
      if (obs_win !== exp_win) begin failures++; $display("FAIL rnd_win f=%0d got=%0d exp=%0d", f, obs_win, exp_win); end
      checks++;
      if (n_sh !== int'(sh) || n_dn !== 1) begin
        failures++; $display("FAIL rnd_pulses f=%0d got=short%0d done%0d exp=%0d/1", f, n_sh, n_dn, sh);
      end
      checks++;
      if (oFRAME_CNT !== 16'(m_frames)) begin failures++; $display("FAIL rnd_cnt got=%0d exp=%0d", oFRAME_CNT, m_frames); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iFVAL = 1'b0; iDVAL = 1'b0; iMODE_WR = 1'b0; iMODE = 2'd0; rst = 1'b1;
    m_mode = 2'd0; m_pend = 1'b0; m_pend_mode = 2'd0; m_frames = 0;
    test_reset();
    test_full_frame();
    test_mode_write();
    test_coincident();
    test_short();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
